// File: rtl/cc_fill_pkg.sv
// -----------------------------------------------------------------------------
// cc_fill_pkg
// Shared types and helpers for the cache line-fill engine.
//   fill_state_t : fill FSM states (IDLE, FILL, WRITE)
//   RRESP_OKAY   : AXI OKAY response code
//   slot_idx()   : line slot for a beat, (start + cnt) modulo beats
// -----------------------------------------------------------------------------
package cc_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } fill_state_t;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  // Beats arrive critical-word-first, so beat cnt of a burst that started at
  // slot 'start' lands at (start + cnt) wrapped around the line.
  function automatic int unsigned slot_idx(input int unsigned start,
                                           input int unsigned cnt,
                                           input int unsigned beats);
    return (start + cnt) % beats;
  endfunction

endpackage

// File: rtl/cc_line_fill_unit_if.sv
// -----------------------------------------------------------------------------
// cc_line_fill_unit_if
// AXI read-data (R) channel bundle between memory and the line-fill engine.
//   rdata  : beat data (DATA_W)
//   rvalid : beat valid
//   rlast  : last beat of burst
//   rresp  : AXI response, non-zero is an error
//   rready : beat accepted by the fill engine
// Modports: master = memory side, slave = fill engine.
// -----------------------------------------------------------------------------
interface cc_line_fill_unit_if #(
  parameter int DATA_W = 64
) ();

  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic [1:0]        rresp;
  logic              rready;

  modport master (output rdata, output rvalid, output rlast, output rresp,
                  input  rready);

  modport slave  (input  rdata, input  rvalid, input  rlast, input  rresp,
                  output rready);

endinterface

// File: rtl/cc_line_buffer.sv
// -----------------------------------------------------------------------------
// cc_line_buffer
// Line assembly register: one DATA_W slot per beat, written one slot at a time.
//   clk, rst_n : clock, synchronous active-low reset (clears the line to 0)
//   wr_en      : write wr_data into slot wr_slot
//   wr_slot    : slot index, 0..BEATS-1
//   wr_data    : beat data
//   line_o     : whole line, slot k at [(BEATS-k)*DATA_W-1 -: DATA_W]
// -----------------------------------------------------------------------------
module cc_line_buffer #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  localparam int SLOT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [SLOT_W-1:0]       wr_slot,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [BEATS*DATA_W-1:0] line_o
);

  logic [BEATS*DATA_W-1:0] r_line;

  // NOTE: this is a flop array, not an SRAM macro, so it can take a reset;
  // clearing it keeps the SRAM data bus deterministic out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line <= '0;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (wr_en && (wr_slot == SLOT_W'(k))) begin
          r_line[(BEATS-k)*DATA_W-1 -: DATA_W] <= wr_data;
        end
      end
    end
  end

  assign line_o = r_line;

endmodule

// File: rtl/cc_line_fill_unit.sv
// -----------------------------------------------------------------------------
// cc_line_fill_unit
// Line-fill engine: pairs each miss address from the miss-address FIFO with
// its critical-word-first read burst, assembles the line and writes it plus
// {valid, tag} to the cache SRAM in one cycle. Bursts with a bad response or
// an rlast in the wrong place are dropped (FIFO still popped, no write).
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   mem (slave)             : AXI R channel; rready is owned here
//   miss_addr_fifo_empty_i  : miss FIFO empty
//   miss_addr_fifo_rdata_i  : miss FIFO head (first-word-fall-through)
//   miss_addr_fifo_rden_o   : pop miss FIFO head
//   wren_o                  : SRAM write enable
//   waddr_o                 : SRAM index
//   wdata_tag_o             : {valid=1, tag}
//   wdata_data_o            : assembled line, slot 0 in the MSBs
//   fill_done_o             : one-cycle pulse per completed fill
//   fill_err_o              : one-cycle pulse with fill_done_o on a bad fill
//   cwf_valid_o, cwf_data_o : critical-word forward (only with CC_FILL_CWF_EN)
//
// Build option: define CC_FILL_CWF_EN to add critical-word forwarding.
// -----------------------------------------------------------------------------
module cc_line_fill_unit
  import cc_fill_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 9,
  localparam int BEATS  = LINE_BYTES * 8 / DATA_W,
  localparam int OFF_W  = $clog2(LINE_BYTES),
  localparam int BOFF_W = $clog2(DATA_W / 8),
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cc_line_fill_unit_if.slave      mem,
  input  logic                    miss_addr_fifo_empty_i,
  input  logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i,
  output logic                    miss_addr_fifo_rden_o,
  output logic                    wren_o,
  output logic [IDX_W-1:0]        waddr_o,
  output logic [TAG_W:0]          wdata_tag_o,
  output logic [LINE_BYTES*8-1:0] wdata_data_o,
  output logic                    fill_done_o,
  output logic                    fill_err_o
`ifdef CC_FILL_CWF_EN
  ,
  output logic                    cwf_valid_o,
  output logic [DATA_W-1:0]       cwf_data_o
`endif
);

  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam int SLOT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [SLOT_W-1:0] r_start;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_rready;
  logic              r_wren;
  logic              r_rden;
  logic              r_done;
  logic              r_fill_err;

  logic              w_hs;
  logic              w_cnt_last;
  logic              w_beat_err;
  logic              w_err_next;
  logic              w_fill_end;
  logic [SLOT_W-1:0] w_slot;
  logic [SLOT_W-1:0] w_start_new;
  logic              w_unused_off;

  // r_rready is only ever high in FILL, so it doubles as the state qualifier.
  assign w_hs       = r_rready & mem.rvalid;
  assign w_cnt_last = (r_cnt == CNT_W'(BEATS - 1));
  assign w_fill_end = mem.rlast | w_cnt_last;

  // Error sources: bad response, rlast before the final beat, or no rlast on it.
  assign w_beat_err = (mem.rresp != RRESP_OKAY)
                    | (mem.rlast & (r_cnt < CNT_W'(BEATS - 1)))
                    | (~mem.rlast & w_cnt_last);
  assign w_err_next = r_err | w_beat_err;

  assign w_slot = SLOT_W'(slot_idx(32'(r_start), 32'(r_cnt), BEATS));

  // Critical-word offset selects the first slot; a single-beat line has none.
  generate
    if (BEATS > 1) begin : g_start
      assign w_start_new = miss_addr_fifo_rdata_i[OFF_W-1:BOFF_W];
    end else begin : g_start_zero
      assign w_start_new = '0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_start    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_rready   <= 1'b0;
      r_wren     <= 1'b0;
      r_rden     <= 1'b0;
      r_done     <= 1'b0;
      r_fill_err <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only on the FILL->WRITE edge.
      r_wren     <= 1'b0;
      r_rden     <= 1'b0;
      r_done     <= 1'b0;
      r_fill_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!miss_addr_fifo_empty_i) begin
            r_addr   <= miss_addr_fifo_rdata_i;
            r_start  <= w_start_new;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rready <= 1'b1;
            r_state  <= FILL;
          end
        end
        FILL: begin
          if (w_hs) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_err <= w_err_next;
            if (w_fill_end) begin
              r_rready   <= 1'b0;
              r_wren     <= ~w_err_next;
              r_rden     <= 1'b1;
              r_done     <= 1'b1;
              r_fill_err <= w_err_next;
              r_state    <= WRITE;
            end
          end
        end
        WRITE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  cc_line_buffer #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_hs),
    .wr_slot (w_slot),
    .wr_data (mem.rdata),
    .line_o  (wdata_data_o)
  );

`ifdef CC_FILL_CWF_EN
  logic              r_cwf_valid;
  logic [DATA_W-1:0] r_cwf_data;

  // Forward the critical word as soon as it lands, even if it errored;
  // the consumer pairs it with fill_err_o later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cwf_valid <= 1'b0;
      r_cwf_data  <= '0;
    end else begin
      r_cwf_valid <= w_hs & (r_cnt == '0);
      if (w_hs && (r_cnt == '0)) begin
        r_cwf_data <= mem.rdata;
      end
    end
  end

  assign cwf_valid_o = r_cwf_valid;
  assign cwf_data_o  = r_cwf_data;
`endif

  // Offset bits of the latched address are not needed after the start slot.
  assign w_unused_off = ^r_addr[OFF_W-1:0];

  assign mem.rready            = r_rready;
  assign miss_addr_fifo_rden_o = r_rden;
  assign wren_o                = r_wren;
  assign fill_done_o           = r_done;
  assign fill_err_o            = r_fill_err;
  assign waddr_o               = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign wdata_tag_o           = {1'b1, r_addr[ADDR_W-1:ADDR_W-TAG_W]};

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// -----------------------------------------------------------------------------
// tb_cc_line_fill_unit
// Directed bench: instance A uses default parameters (8 x 64-bit beats),
// instance B uses DATA_W=128, LINE_BYTES=32 (2 beats). Each instance has a
// small FIFO model; monitors count pops, SRAM writes and R handshakes.
// -----------------------------------------------------------------------------
module tb_cc_line_fill_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  cc_line_fill_unit_if #(.DATA_W(64)) mem_a ();

  logic [31:0]  fa_mem [8];
  logic [7:0]   fa_wr = '0;
  logic [7:0]   fa_rd = '0;
  logic         fa_empty;
  logic [31:0]  fa_head;
  logic         a_rden, a_wren, a_done, a_err;
  logic [8:0]   a_waddr;
  logic [17:0]  a_tag;
  logic [511:0] a_data;
  int           a_pops = 0, a_writes = 0, a_hs = 0;

  assign fa_empty = (fa_wr == fa_rd);
  assign fa_head  = fa_mem[fa_rd[2:0]];

`ifdef CC_FILL_CWF_EN
  logic        a_cwf_valid;
  logic [63:0] a_cwf_data;
`endif

  cc_line_fill_unit u_dut_a (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mem                    (mem_a),
    .miss_addr_fifo_empty_i (fa_empty),
    .miss_addr_fifo_rdata_i (fa_head),
    .miss_addr_fifo_rden_o  (a_rden),
    .wren_o                 (a_wren),
    .waddr_o                (a_waddr),
    .wdata_tag_o            (a_tag),
    .wdata_data_o           (a_data),
    .fill_done_o            (a_done),
    .fill_err_o             (a_err)
`ifdef CC_FILL_CWF_EN
    ,
    .cwf_valid_o            (a_cwf_valid),
    .cwf_data_o             (a_cwf_data)
`endif
  );

  always @(posedge clk) begin
    if (a_rden) begin
      fa_rd  <= fa_rd + 8'd1;
      a_pops <= a_pops + 1;
    end
    if (a_wren) a_writes <= a_writes + 1;
    if (mem_a.rvalid && mem_a.rready) a_hs <= a_hs + 1;
  end

  // ---------------- instance B: 2 x 128-bit beats ----------------
  cc_line_fill_unit_if #(.DATA_W(128)) mem_b ();

  logic [31:0]  fb_mem [8];
  logic [7:0]   fb_wr = '0;
  logic [7:0]   fb_rd = '0;
  logic         fb_empty;
  logic [31:0]  fb_head;
  logic         b_rden, b_wren, b_done, b_err;
  logic [8:0]   b_waddr;
  logic [18:0]  b_tag;
  logic [255:0] b_data;
  int           b_pops = 0, b_writes = 0;

  assign fb_empty = (fb_wr == fb_rd);
  assign fb_head  = fb_mem[fb_rd[2:0]];

`ifdef CC_FILL_CWF_EN
  logic         b_cwf_valid;
  logic [127:0] b_cwf_data;
`endif

  cc_line_fill_unit #(
    .DATA_W     (128),
    .LINE_BYTES (32),
    .ADDR_W     (32),
    .IDX_W      (9)
  ) u_dut_b (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mem                    (mem_b),
    .miss_addr_fifo_empty_i (fb_empty),
    .miss_addr_fifo_rdata_i (fb_head),
    .miss_addr_fifo_rden_o  (b_rden),
    .wren_o                 (b_wren),
    .waddr_o                (b_waddr),
    .wdata_tag_o            (b_tag),
    .wdata_data_o           (b_data),
    .fill_done_o            (b_done),
    .fill_err_o             (b_err)
`ifdef CC_FILL_CWF_EN
    ,
    .cwf_valid_o            (b_cwf_valid),
    .cwf_data_o             (b_cwf_data)
`endif
  );

  always @(posedge clk) begin
    if (b_rden) begin
      fb_rd  <= fb_rd + 8'd1;
      b_pops <= b_pops + 1;
    end
    if (b_wren) b_writes <= b_writes + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_a(input logic [31:0] addr);
    fa_mem[fa_wr[2:0]] = addr;
    fa_wr = fa_wr + 8'd1;
  endtask

  task automatic push_b(input logic [31:0] addr);
    fb_mem[fb_wr[2:0]] = addr;
    fb_wr = fb_wr + 8'd1;
  endtask

  // Present one beat and return #1 after the edge on which it was accepted.
  task automatic beat_a(input logic [63:0] d, input logic [1:0] rs, input logic l);
    int g = 0;
    mem_a.rvalid = 1'b1;
    mem_a.rdata  = d;
    mem_a.rresp  = rs;
    mem_a.rlast  = l;
    while (mem_a.rready !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) check("a_rready_timeout", {511'b0, mem_a.rready}, 512'd1);
    @(posedge clk); #1;
    mem_a.rvalid = 1'b0;
    mem_a.rlast  = 1'b0;
    mem_a.rresp  = 2'b00;
  endtask

  task automatic beat_b(input logic [127:0] d, input logic [1:0] rs, input logic l);
    int g = 0;
    mem_b.rvalid = 1'b1;
    mem_b.rdata  = d;
    mem_b.rresp  = rs;
    mem_b.rlast  = l;
    while (mem_b.rready !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) check("b_rready_timeout", {511'b0, mem_b.rready}, 512'd1);
    @(posedge clk); #1;
    mem_b.rvalid = 1'b0;
    mem_b.rlast  = 1'b0;
    mem_b.rresp  = 2'b00;
  endtask

  // Burst of n beats base+0..base+n-1; err_idx gets SLVERR, last_idx gets rlast.
  task automatic fill_a(input logic [63:0] base, input int n,
                        input int err_idx, input int last_idx);
    for (int i = 0; i < n; i++) begin
      beat_a(base + 64'(i), (i == err_idx) ? 2'b10 : 2'b00, (i == last_idx));
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [511:0] exp_line;
  int           hs_before;

  initial begin
    rst_n        = 1'b0;
    mem_a.rvalid = 1'b0; mem_a.rdata = '0; mem_a.rresp = 2'b00; mem_a.rlast = 1'b0;
    mem_b.rvalid = 1'b0; mem_b.rdata = '0; mem_b.rresp = 2'b00; mem_b.rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_rready", {511'b0, mem_a.rready}, 512'd0);
    check("rst_wren",   {511'b0, a_wren},       512'd0);
    check("rst_rden",   {511'b0, a_rden},       512'd0);
    check("rst_done",   {510'b0, a_done, a_err}, 512'd0);
    check("rst_line_a", a_data,                  512'd0);
    check("rst_line_b", {256'b0, b_data},        512'd0);

    // Fill 1: addr 0x1234_5640, start slot 0, idx = addr[14:6] = 0x159,
    // tag = addr[31:15] = 0x02468
    push_a(32'h1234_5640);
    @(posedge clk); #1;
    check("t1_rready_lat", {511'b0, mem_a.rready}, 512'd1);
    fill_a(64'hD0D0_0000_0000_0000, 8, -1, 7);
    check("t1_wren",  {511'b0, a_wren},  512'd1);
    check("t1_rden",  {511'b0, a_rden},  512'd1);
    check("t1_done_err", {510'b0, a_done, a_err}, 512'd2);
    check("t1_waddr", {503'b0, a_waddr}, {503'b0, 9'h159});
    check("t1_tag",   {494'b0, a_tag},   {494'b0, 18'h22468});
    exp_line = '0;
    for (int k = 0; k < 8; k++)
      exp_line[(8-k)*64-1 -: 64] = 64'hD0D0_0000_0000_0000 + 64'(k);
    check("t1_line",  a_data, exp_line);
    check("t1_slot0", {448'b0, a_data[511:448]}, {448'b0, 64'hD0D0_0000_0000_0000});
    @(posedge clk); #1;
    check("t1_wren_pulse", {511'b0, a_wren}, 512'd0);
    check("t1_pops",   512'(a_pops),   512'd1);
    check("t1_writes", 512'(a_writes), 512'd1);

    // Fill 2: addr 0x58, start slot 3, wrap-around placement
    push_a(32'h0000_0058);
    fill_a(64'hB0B0_0000_0000_0000, 8, -1, 7);
    check("t2_wren",  {511'b0, a_wren},  512'd1);
    check("t2_waddr", {503'b0, a_waddr}, {503'b0, 9'h001});
    check("t2_tag",   {494'b0, a_tag},   {494'b0, 18'h20000});
    check("t2_b0_s3", {448'b0, a_data[319:256]}, {448'b0, 64'hB0B0_0000_0000_0000});
    check("t2_b4_s7", {448'b0, a_data[63:0]},    {448'b0, 64'hB0B0_0000_0000_0004});
    check("t2_b5_s0", {448'b0, a_data[511:448]}, {448'b0, 64'hB0B0_0000_0000_0005});
    check("t2_b7_s2", {448'b0, a_data[383:320]}, {448'b0, 64'hB0B0_0000_0000_0007});

    // Fill 3: SLVERR on the 4th beat
    push_a(32'h0000_1000);
    fill_a(64'hE0E0_0000_0000_0000, 8, 3, 7);
    check("t3_wren", {511'b0, a_wren}, 512'd0);
    check("t3_done_err", {510'b0, a_done, a_err}, 512'd3);
    check("t3_rden", {511'b0, a_rden}, 512'd1);
    @(posedge clk); #1;
    check("t3_pops",   512'(a_pops),   512'd3);
    check("t3_writes", 512'(a_writes), 512'd2);

    // Fill 4: early rlast on the 5th beat, then a queued normal fill
    push_a(32'h0000_2000);
    push_a(32'h0000_3040);
    fill_a(64'hA0A0_0000_0000_0000, 5, -1, 4);
    check("t4_early_wren", {511'b0, a_wren}, 512'd0);
    check("t4_early_done_err", {510'b0, a_done, a_err}, 512'd3);
    fill_a(64'hC0C0_0000_0000_0000, 8, -1, 7);
    check("t4_next_wren",  {511'b0, a_wren}, 512'd1);
    check("t4_next_err",   {511'b0, a_err},  512'd0);
    check("t4_next_waddr", {503'b0, a_waddr}, {503'b0, 9'h0C1});
    check("t4_next_s0",    {448'b0, a_data[511:448]}, {448'b0, 64'hC0C0_0000_0000_0000});
    check("t4_next_s7",    {448'b0, a_data[63:0]},    {448'b0, 64'hC0C0_0000_0000_0007});
    @(posedge clk); #1;
    check("t4_pops",   512'(a_pops),   512'd5);
    check("t4_writes", 512'(a_writes), 512'd3);

    // Stall: rvalid high with an empty FIFO must not be accepted
    mem_a.rvalid = 1'b1;
    mem_a.rdata  = 64'h5555_0000_0000_0000;
    hs_before    = a_hs;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("t5_stall_rready", {511'b0, mem_a.rready}, 512'd0);
    end
    check("t5_stall_hs", 512'(a_hs - hs_before), 512'd0);
    push_a(32'h0000_4000);
    @(posedge clk); #1;
    check("t5_rready_lat", {511'b0, mem_a.rready}, 512'd1);
    fill_a(64'h5555_0000_0000_0000, 8, -1, 7);
    check("t5_hs",   512'(a_hs - hs_before), 512'd8);
    check("t5_wren", {511'b0, a_wren}, 512'd1);
    check("t5_s0",   {448'b0, a_data[511:448]}, {448'b0, 64'h5555_0000_0000_0000});

    // Instance B: addr 0x1230, start slot 1, idx 0x091, tag 0
    push_b(32'h0000_1230);
    beat_b(128'hE0E0_0000_0000_0000_0000_0000_0000_0000, 2'b00, 1'b0);
`ifdef CC_FILL_CWF_EN
    check("b_cwf_valid", {511'b0, b_cwf_valid}, 512'd1);
    check("b_cwf_data",  {384'b0, b_cwf_data},
          {384'b0, 128'hE0E0_0000_0000_0000_0000_0000_0000_0000});
`endif
    beat_b(128'hE1E1_0000_0000_0000_0000_0000_0000_0001, 2'b00, 1'b1);
`ifdef CC_FILL_CWF_EN
    check("b_cwf_pulse", {511'b0, b_cwf_valid}, 512'd0);
`endif
    check("b_wren",  {511'b0, b_wren},  512'd1);
    check("b_waddr", {503'b0, b_waddr}, {503'b0, 9'h091});
    check("b_tag",   {493'b0, b_tag},   {493'b0, 19'h40000});
    check("b_line",  {256'b0, b_data},
          {256'b0, 128'hE1E1_0000_0000_0000_0000_0000_0000_0001,
                   128'hE0E0_0000_0000_0000_0000_0000_0000_0000});
    @(posedge clk); #1;
    check("b_pops", 512'(b_pops), 512'd1);

    // Instance B: reset in the middle of a fill abandons it
    push_b(32'h0000_2460);
    beat_b(128'h7777, 2'b00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("b_rst_rready", {511'b0, mem_b.rready}, 512'd0);
    check("b_rst_wren",   {511'b0, b_wren},       512'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("b_rst_pops",   512'(b_pops),   512'd1);
    check("b_rst_writes", 512'(b_writes), 512'd1);
    check("b_rst_refill", {511'b0, mem_b.rready}, 512'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
